// File: rtl/wb_host_pkg.sv
// Shared types and defaults for the Wishbone host initiator.
package wb_host_pkg;

    localparam int WB_WIDTH_DEF = 32;
    localparam int SEL_W        = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        RESP = 2'd2
    } wb_state_e;

    typedef struct packed {
        logic [WB_WIDTH_DEF-1:0] rdata;
        logic                    err;
        logic                    timeout;
    } wb_rsp_t;

endpackage

// File: rtl/wb_host_timeout.sv
// Saturating bus-cycle counter that flags expiry after TO_CYCLES strobe cycles.
module wb_host_timeout #(
    parameter int TO_CYCLES = 255,
    parameter int TO_W      = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expire
);

    logic [TO_W-1:0] cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (clr) begin
            cnt_q <= '0;
        end else if (en && (cnt_q != {TO_W{1'b1}})) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    // Counter reads 0 in the first strobe cycle, so stb stays up TO_CYCLES cycles.
    assign expire = en && (cnt_q == TO_W'(TO_CYCLES - 1));

endmodule

// File: rtl/wb_host_master.sv
// Wishbone classic initiator: one command in, one single read/write cycle out, one response back.
module wb_host_master
    import wb_host_pkg::*;
#(
    parameter int WB_WIDTH  = WB_WIDTH_DEF,
    parameter int TO_CYCLES = 255,
    parameter int TO_W      = 8
) (
    input  logic                wb_clk_i,
    input  logic                wb_rst_i,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic                cmd_we,
    input  logic [WB_WIDTH-1:0] cmd_addr,
    input  logic [WB_WIDTH-1:0] cmd_wdata,
    input  logic [SEL_W-1:0]    cmd_sel,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [WB_WIDTH-1:0] rsp_rdata,
    output logic                rsp_err,
    output logic                rsp_timeout,
    output logic                wbm_cyc_o,
    output logic                wbm_stb_o,
    output logic                wbm_we_o,
    output logic [WB_WIDTH-1:0] wbm_adr_o,
    output logic [WB_WIDTH-1:0] wbm_dat_o,
    output logic [SEL_W-1:0]    wbm_sel_o,
    input  logic [WB_WIDTH-1:0] wbm_dat_i,
    input  logic                wbm_ack_i,
    input  logic                wbm_err_i,
    output logic                busy_o
);

    wb_state_e state_q, state_d;
    wb_rsp_t   rsp_q, rsp_d;
    logic      to_expire;
    logic      to_clr;

    // Timeout counter clears on the RESP->IDLE handshake and holds otherwise.
    assign to_clr = (state_q == RESP) && rsp_ready;

    wb_host_timeout #(
        .TO_CYCLES (TO_CYCLES),
        .TO_W      (TO_W)
    ) u_timeout (
        .clk    (wb_clk_i),
        .rst    (wb_rst_i),
        .clr    (to_clr),
        .en     (state_q == BUS),
        .expire (to_expire)
    );

    always_comb begin
        state_d = state_q;
        rsp_d   = rsp_q;
        case (state_q)
            IDLE: begin
                if (cmd_valid) state_d = BUS;
            end
            BUS: begin
                if (wbm_err_i) begin
                    state_d       = RESP;
                    rsp_d.rdata   = '0;
                    rsp_d.err     = 1'b1;
                    rsp_d.timeout = 1'b0;
                end else if (wbm_ack_i) begin
                    state_d       = RESP;
                    rsp_d.rdata   = wbm_we_o ? '0 : wbm_dat_i;
                    rsp_d.err     = 1'b0;
                    rsp_d.timeout = 1'b0;
                end else if (to_expire) begin
                    state_d       = RESP;
                    rsp_d.rdata   = '0;
                    rsp_d.err     = 1'b1;
                    rsp_d.timeout = 1'b1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d       = IDLE;
                    rsp_d.err     = 1'b0;
                    rsp_d.timeout = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q   <= IDLE;
            rsp_q     <= '0;
            wbm_we_o  <= 1'b0;
            wbm_adr_o <= '0;
            wbm_dat_o <= '0;
            wbm_sel_o <= '0;
        end else begin
            state_q <= state_d;
            rsp_q   <= rsp_d;
            if ((state_q == IDLE) && cmd_valid) begin
                wbm_we_o  <= cmd_we;
                wbm_adr_o <= cmd_addr;
                wbm_dat_o <= cmd_wdata;
                wbm_sel_o <= cmd_sel;
            end
        end
    end

    // Handshake and strobe signals decode straight from the state register, so reset drops them at once.
    assign cmd_ready   = (state_q == IDLE);
    assign wbm_cyc_o   = (state_q == BUS);
    assign wbm_stb_o   = (state_q == BUS);
    assign rsp_valid   = (state_q == RESP);
    assign busy_o      = (state_q != IDLE);
    assign rsp_rdata   = rsp_q.rdata;
    assign rsp_err     = rsp_q.err;
    assign rsp_timeout = rsp_q.timeout;

endmodule
